// File: rtl/disp_pkg.sv
// Shared definitions for the display scan controller.
//   NUM_DIGITS   - anodes on the board display
//   AN_OFF       - anode bus value with every digit dark (anodes are active-low)
//   scan_state_t - per-slot phase: BLANK (anti-ghosting gap) then SHOW
//   an_select    - active-low one-hot anode pattern for a digit index
package disp_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam int         IDX_W      = 3;
   localparam logic [7:0] AN_OFF     = 8'hFF;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   function automatic logic [7:0] an_select(input logic [IDX_W-1:0] idx);
      return ~(8'h01 << idx);
   endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_timer.sv
// Slot timing for the display scan.
//   clk, reset      - system clock, asynchronous active-high reset
//   idx             - digit currently owning the shared decoder (0..7)
//   state           - BLANK for the first BLANK_CYC cycles of a slot, SHOW after
//   frame_done      - registered pulse during the last cycle of the digit-7 slot
//   frame_done_nxt  - frame_done as it will be next cycle, for callers that
//                     want to register their own pulse in step with frame_done
module scan_timer
   import disp_pkg::*;
#(
   parameter int DWELL_CYC = 100000,
   parameter int BLANK_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic [IDX_W-1:0] idx,
   output scan_state_t      state,
   output logic             frame_done,
   output logic             frame_done_nxt
);

   localparam int               CNT_W     = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   scan_state_t      state_nxt;
   logic             wrap;

   // State is derived from the next count so that the registered state
   // always agrees with the registered cnt (BLANK exactly while cnt < BLANK_CYC).
   always_comb begin
      wrap           = (cnt == CNT_LAST);
      cnt_nxt        = wrap ? '0 : cnt + 1'b1;
      idx_nxt        = wrap ? idx + 1'b1 : idx;
      state_nxt      = (cnt_nxt < CNT_BLANK) ? BLANK : SHOW;
      frame_done_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         state      <= (BLANK_CYC > 0) ? BLANK : SHOW;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         state      <= state_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display driver feeding one external BCD-to-7-segment
// decoder.
//   clk, reset     - system clock, asynchronous active-high reset
//   digits_in      - 8 BCD nibbles, [3:0] is digit 0 (an[0])
//   en_in          - per-digit enable (0 = dark)
//   blink_mask_in  - per-digit blink select
//   blink_en       - live global blink enable
//   load           - one-cycle strobe staging the three inputs above
//   x              - nibble to the decoder, aligned with an
//   an             - active-low anode drive
//   load_ack       - pulse when staged data becomes the displayed data
//   frame_done     - pulse during the last cycle of the digit-7 slot
//
// Load handshake: load is a fire-and-forget strobe (no ready). Every load
// overwrites the staging registers and marks them pending. In the frame_done
// cycle a pending staging set is copied to the shadow registers and load_ack
// pulses in that same cycle; at most one ack per frame boundary, last write
// wins. A load landing in the frame_done cycle itself stays pending for the
// following boundary.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int DWELL_CYC    = 100000,
   parameter int BLANK_CYC    = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] digits_in,
   input  logic [7:0]  en_in,
   input  logic [7:0]  blink_mask_in,
   input  logic        blink_en,
   input  logic        load,
   output logic [3:0]  x,
   output logic [7:0]  an,
   output logic        load_ack,
   output logic        frame_done
);

   localparam int            BL_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

   logic [IDX_W-1:0] idx;
   scan_state_t      state;
   logic             frame_done_nxt;

   logic [31:0] st_digits;
   logic [7:0]  st_en;
   logic [7:0]  st_blink;
   logic        pending;
   logic        pending_nxt;
   logic        commit;

   logic [31:0] sh_digits;
   logic [7:0]  sh_en;
   logic [7:0]  sh_blink;

   logic [BL_W-1:0] blink_cnt;
   logic            blink_phase;
   logic            visible;

   scan_timer #(
      .DWELL_CYC (DWELL_CYC),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk            (clk),
      .reset          (reset),
      .idx            (idx),
      .state          (state),
      .frame_done     (frame_done),
      .frame_done_nxt (frame_done_nxt)
   );

   always_comb begin
      commit      = frame_done & pending;
      pending_nxt = load | (pending & ~commit);
      visible     = sh_en[idx] & ~(blink_en & blink_phase & sh_blink[idx]);
   end

   // Staging, pending flag and shadow registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_digits <= '0;
         st_en     <= '0;
         st_blink  <= '0;
         pending   <= 1'b0;
         sh_digits <= '0;
         sh_en     <= '0;
         sh_blink  <= '0;
      end else begin
         if (load) begin
            st_digits <= digits_in;
            st_en     <= en_in;
            st_blink  <= blink_mask_in;
         end
         pending <= pending_nxt;
         // Commit uses the staging contents from before any same-cycle load.
         if (commit) begin
            sh_digits <= st_digits;
            sh_en     <= st_en;
            sh_blink  <= st_blink;
         end
      end
   end

   // Blink phase keeps running even while blink_en is low so that
   // re-enabling blink does not restart the cadence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_done) begin
         if (blink_cnt == BL_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Registered display outputs. load_ack is registered one cycle early
   // (from the next-cycle frame boundary and pending) so it lands in the
   // frame_done cycle exactly when the commit happens.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an       <= AN_OFF;
         x        <= '0;
         load_ack <= 1'b0;
      end else begin
         an       <= (state == SHOW && visible) ? an_select(idx) : AN_OFF;
         x        <= sh_digits[{idx, 2'b00} +: 4];
         load_ack <= frame_done_nxt & pending_nxt;
      end
   end

endmodule
